// File: rtl/mem_access_unit.sv
// Memory-access stage: turns controller strobes into a req/ack access on a variable-latency memory,
// owns the instruction and data registers, and stalls the controller. Optional macro: MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              IRWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                stall_c;
  logic                timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter sits at zero outside ACCESS, so it restarts on every entry.
  assign cnt_d       = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_c = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemWrite || MemRead || IRWrite) begin
          stall_c = 1'b1;
          addr_d  = Adr;
          wdata_d = WriteData;
          op_d    = MemWrite ? OP_STORE : (MemRead ? OP_LOAD : OP_FETCH);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        mem_req = 1'b1;
        mem_we  = (op_q == OP_STORE);
        if (mem_ack) begin
          if (op_q == OP_FETCH) instr_d = mem_rdata;
          if (op_q == OP_LOAD)  rdata_d = mem_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes may still be high while reset is asserted; Stall must read 0 then.
  assign Stall     = stall_c & reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Instr     = instr_q;
  assign ReadData  = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level model of
// instruction/data registers, stall length and error flag.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Adr;
  logic [DW-1:0] WriteData;
  logic          IRWrite, MemRead, MemWrite;
  logic [DW-1:0] Instr, ReadData;
  logic          Stall, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          err;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Instr(Instr), .ReadData(ReadData), .Stall(Stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: architectural registers as seen by the controller.
  logic [DW-1:0] exp_instr = '0;
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_strobes(input logic irw, input logic mr, input logic mw);
    IRWrite  = irw;
    MemRead  = mr;
    MemWrite = mw;
  endtask

  // One access: IDLE cycle with strobes, (wait_c+1) ACCESS cycles, then DONE.
  task automatic run_txn(input logic irw, input logic mr, input logic mw,
                         input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input int wait_c);
    logic is_store;
    int   stall_cycles;
    is_store     = mw;
    stall_cycles = 0;
    @(negedge clk);
    set_strobes(irw, mr, mw);
    Adr = adr; WriteData = wd; mem_ack = 1'b0;
    #1;
    if (Stall) stall_cycles++;
    check("idle_req", mem_req, 1'b0);
    for (int j = 0; j <= wait_c; j++) begin
      @(negedge clk);
      mem_ack   = (j == wait_c);
      mem_rdata = (j == wait_c) ? rd : DW'($urandom);
      Adr       = AW'($urandom);
      WriteData = DW'($urandom);
      #1;
      if (Stall) stall_cycles++;
      check("acc_req", mem_req, 1'b1);
      check("acc_we", mem_we, is_store);
      check("acc_addr", mem_addr, adr);
      if (is_store) check("acc_wdata", mem_wdata, wd);
    end
    if (mw)       ;
    else if (mr)  exp_rdata = rd;
    else if (irw) exp_instr = rd;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stall_len", stall_cycles, wait_c + 2);
    check("done_stall", Stall, 1'b0);
    check("done_req", mem_req, 1'b0);
    check("done_instr", Instr, exp_instr);
    check("done_rdata", ReadData, exp_rdata);
    check("done_err", err, exp_err);
  endtask

  task automatic idle_cycle(input logic spurious_ack);
    @(negedge clk);
    set_strobes(1'b0, 1'b0, 1'b0);
    mem_ack   = spurious_ack;
    mem_rdata = DW'($urandom);
    #1;
    check("idle_stall", Stall, 1'b0);
    check("idle_req", mem_req, 1'b0);
    check("idle_instr", Instr, exp_instr);
    check("idle_rdata", ReadData, exp_rdata);
  endtask

  task automatic run_random(input int n);
    logic [2:0] s;
    for (int i = 0; i < n; i++) begin
      s = 3'($urandom_range(7, 1));
      run_txn(s[0], s[1], s[2], AW'($urandom), DW'($urandom), DW'($urandom),
              int'($urandom_range(8, 0)));
      if ($urandom_range(3, 0) == 0) begin
        idle_cycle(1'b1);
        idle_cycle(1'b0);
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic run_timeout();
    @(negedge clk);
    set_strobes(1'b0, 1'b1, 1'b0);
    Adr = 32'h100; mem_ack = 1'b0;
    for (int j = 0; j < TO; j++) begin
      @(negedge clk);
      #1;
      check("to_req", mem_req, 1'b1);
    end
    exp_err = 1'b1;
    @(negedge clk);
    set_strobes(1'b0, 1'b0, 1'b0);
    #1;
    check("to_req_drop", mem_req, 1'b0);
    check("to_err", err, 1'b1);
    check("to_rdata", ReadData, exp_rdata);
    check("to_stall", Stall, 1'b0);
  endtask
`endif

  initial begin
    reset = 1'b0;
    set_strobes(1'b0, 1'b0, 1'b0);
    Adr = '0; WriteData = '0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, '0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_instr", Instr, '0);
    check("rst_rdata", ReadData, '0);
    check("rst_stall", Stall, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_txn(1'b1, 1'b0, 1'b0, 32'h00, 32'h0, 32'hE3A01005, 0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678, 3);
    run_txn(1'b0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 32'h5A5A5A5A, 2);
    run_txn(1'b1, 1'b0, 1'b0, 32'h84, 32'h0, 32'hE1A00000, 1);
    run_txn(1'b1, 1'b0, 1'b1, 32'h90, 32'hCAFEF00D, 32'h0BADC0DE, 0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h94, 32'h0, 32'h13579BDF, 1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    run_random(40);

`ifdef MEM_TIMEOUT_EN
    run_timeout();
    run_random(4);
`endif

    // Reset while the access is in flight, with the fetch strobe still high.
    @(negedge clk);
    set_strobes(1'b1, 1'b0, 1'b0);
    Adr = 32'h200; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_req", mem_req, 1'b1);
    #1;
    reset = 1'b0;
    exp_instr = '0; exp_rdata = '0; exp_err = 1'b0;
    #1;
    check("arst_req", mem_req, 1'b0);
    check("arst_stall", Stall, 1'b0);
    check("arst_instr", Instr, '0);
    check("arst_rdata", ReadData, '0);
    check("arst_err", err, 1'b0);
    @(negedge clk);
    set_strobes(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idle_cycle(1'b0);
    run_random(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
